// File: rtl/out_port_arbiter.sv
// Round-robin arbiter granting one of four frame decoders access to an output FIFO.
// A grant is held for a whole frame and is dropped on tlast, on an idle timeout, or on reset.
module out_port_arbiter #(
    parameter int FIFO_DEPTH      = 1024,
    parameter int MAX_FRAME_WORDS = 380,
    parameter int TIMEOUT         = 255
) (
    input  logic        glb_clk,
    input  logic        glb_areset_n,
    input  logic [3:0]  fd_req,
    input  logic        mon_tvalid,
    input  logic        mon_tready,
    input  logic        mon_tlast,
    input  logic [31:0] fifo_space_used,
    output logic [3:0]  fifo_sel_bits,
    output logic        busy,
    output logic        timeout_err,
    output logic [15:0] frame_cnt
);

    localparam logic [31:0] DEPTH_C        = 32'(FIFO_DEPTH);
    localparam logic [31:0] MAX_WORDS_C    = 32'(MAX_FRAME_WORDS);
    localparam logic [15:0] TIMEOUT_LAST_C = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2
    } state_t;

    // Returns {found, index}; search starts one past the last winner, last winner has lowest priority.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_t      state_r;
    logic [3:0]  sel_r;
    logic        busy_r;
    logic        timeout_err_r;
    logic [15:0] frame_cnt_r;
    logic [1:0]  last_grant_r;
    logic [1:0]  grant_idx_r;
    logic [15:0] idle_cnt_r;

    logic        beat_s;
    logic        space_ok_s;
    logic [2:0]  pick_s;
    logic [3:0]  pick_onehot_s;

    // Beat detection, free-space check and round-robin winner selection.
    always_comb begin
        beat_s = mon_tvalid & mon_tready;
        // An over-full FIFO must not wrap into a huge free-space value.
        if (fifo_space_used > DEPTH_C) begin
            space_ok_s = 1'b0;
        end else begin
            space_ok_s = ((DEPTH_C - fifo_space_used) >= MAX_WORDS_C);
        end
        pick_s        = rr_pick(fd_req, last_grant_r);
        pick_onehot_s = 4'b0001 << pick_s[1:0];
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge glb_clk or negedge glb_areset_n) begin
        if (!glb_areset_n) begin
            state_r       <= ST_IDLE;
            sel_r         <= 4'b0000;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
            frame_cnt_r   <= 16'd0;
            last_grant_r  <= 2'd3;
            grant_idx_r   <= 2'd0;
            idle_cnt_r    <= 16'd0;
        end else begin
            timeout_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_s[2] && space_ok_s) begin
                        sel_r       <= pick_onehot_s;
                        grant_idx_r <= pick_s[1:0];
                        busy_r      <= 1'b1;
                        idle_cnt_r  <= 16'd0;
                        state_r     <= ST_GRANT;
                    end else begin
                        sel_r  <= 4'b0000;
                        busy_r <= 1'b0;
                    end
                end
                ST_GRANT, ST_XFER: begin
                    if (beat_s && mon_tlast) begin
                        sel_r        <= 4'b0000;
                        busy_r       <= 1'b0;
                        last_grant_r <= grant_idx_r;
                        frame_cnt_r  <= frame_cnt_r + 16'd1;
                        idle_cnt_r   <= 16'd0;
                        state_r      <= ST_IDLE;
                    end else if (beat_s) begin
                        idle_cnt_r <= 16'd0;
                        state_r    <= ST_XFER;
                    end else if (idle_cnt_r == TIMEOUT_LAST_C) begin
                        // Stalled source: revoke and move priority past it.
                        timeout_err_r <= 1'b1;
                        sel_r         <= 4'b0000;
                        busy_r        <= 1'b0;
                        last_grant_r  <= grant_idx_r;
                        idle_cnt_r    <= 16'd0;
                        state_r       <= ST_IDLE;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    sel_r      <= 4'b0000;
                    busy_r     <= 1'b0;
                    idle_cnt_r <= 16'd0;
                end
            endcase
        end
    end

    assign fifo_sel_bits = sel_r;
    assign busy          = busy_r;
    assign timeout_err   = timeout_err_r;
    assign frame_cnt     = frame_cnt_r;

endmodule

// File: doc/out_port_arbiter.md
OUT_PORT_ARBITER -- requirements
Module: out_port_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 1024, output FIFO capacity in 4-byte words.
REQ-002 Parameter MAX_FRAME_WORDS, default 380, worst-case frame length in words (1518 B rounded up).
REQ-003 Parameter TIMEOUT, default 255, maximum idle cycles allowed inside a granted frame; legal range 1..65535.
REQ-004 glb_clk  input  1  the only clock; all logic is on its rising edge.
REQ-005 glb_areset_n  input  1  asynchronous, active-low reset.
REQ-006 fd_req  input  4  bit i is set while frame_decoder i has a frame for this output port.
REQ-007 mon_tvalid  input  1  tvalid observed on this output FIFO write port.
REQ-008 mon_tready  input  1  tready observed on this output FIFO write port.
REQ-009 mon_tlast  input  1  tlast observed on this output FIFO write port.
REQ-010 fifo_space_used  input  32  occupied words in this output FIFO.
REQ-011 fifo_sel_bits  output  4  one-hot grant to the crossbar; all zeros means no source.
REQ-012 busy  output  1  high while a grant is held.
REQ-013 timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout.
REQ-014 frame_cnt  output  16  count of frames completed through this port.

Function
REQ-015 A beat is a cycle with mon_tvalid && mon_tready; the end of a frame is a beat with mon_tlast=1.
REQ-016 FSM states: IDLE, GRANT, XFER.
REQ-017 Space check: space_ok = (FIFO_DEPTH - fifo_space_used) >= MAX_FRAME_WORDS, in 32-bit unsigned arithmetic.
REQ-018 If fifo_space_used > FIFO_DEPTH, space_ok is 0 (no underflow wrap).
REQ-019 IDLE: when fd_req!=0 and space_ok, select the winner round-robin starting at index (last_grant+1) mod 4, load fifo_sel_bits, and enter GRANT on the next edge.
REQ-020 Request-to-grant latency is exactly 1 cycle.
REQ-021 IDLE with fd_req=0 or space_ok=0: stay in IDLE with fifo_sel_bits=0.
REQ-022 GRANT: the first beat enters XFER; a beat that is also tlast (single-beat frame) takes the frame-end path of REQ-024 directly.
REQ-023 GRANT or XFER: fifo_sel_bits is held constant regardless of fd_req changes.
REQ-024 Frame end: on the tlast beat, clear fifo_sel_bits, update last_grant to the winner, increment frame_cnt (wrapping at 16 bits), and return to IDLE.
REQ-025 Re-arbitration is allowed in the cycle after IDLE is re-entered, giving a minimum gap of 1 idle cycle between grants.
REQ-026 Idle counter: reset to 0 on every beat and on grant; increments in GRANT/XFER on cycles without a beat.
REQ-027 If the idle counter reaches TIMEOUT, pulse timeout_err, clear fifo_sel_bits, leave frame_cnt unchanged, advance last_grant past the stalled source, and go to IDLE.
REQ-028 Beats observed in IDLE are ignored.
REQ-029 busy = (state != IDLE).
REQ-030 fifo_sel_bits is registered, glitch-free, and never has more than one bit set.

Reset
REQ-031 Reset value of every output is 0: fifo_sel_bits=0, busy=0, timeout_err=0, frame_cnt=0.
REQ-032 Reset sets state=IDLE, last_grant=3 (so index 0 has first priority), and idle counter=0.
REQ-033 Reset asserted mid-frame drops the grant immediately (asynchronously) without incrementing frame_cnt.
REQ-034 After reset deassertion, the first arbitration happens on the first rising edge at which fd_req!=0 and space_ok.

Verification
REQ-035 Scenario: after reset, fd_req=4'b1111 and fifo_space_used=0 -> fifo_sel_bits=0001 one cycle later; then 3-beat frames completed back-to-back -> grants in order 0010, 0100, 1000, 0001; frame_cnt=4 after the fourth frame.
REQ-036 Scenario: fifo_space_used=645 (free space 379) with fd_req=0001 -> no grant; drop fifo_space_used to 644 -> fifo_sel_bits=0001 next cycle.
REQ-037 Scenario: grant to source 2, then fd_req changes to 0001 mid-frame -> fifo_sel_bits stays 0100 until the tlast beat, then returns to 0000.
REQ-038 Scenario: granted, with no beat for 255 cycles -> timeout_err pulses exactly 1 cycle, fifo_sel_bits=0, frame_cnt unchanged, next grant goes to the next requester in round-robin order.
REQ-039 Scenario: single-beat frame (tlast on the first beat in GRANT) -> frame_cnt +1 and return to IDLE the following cycle.
REQ-040 Scenario: glb_areset_n pulsed low during XFER -> all outputs 0 immediately; after release with fd_req=1000 -> grant 1000 one cycle later.
